// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction: decodes comparator flags into a taken decision,
// flags mispredictions, and keeps a direct-mapped table of 2-bit counters with tags/targets.
module branch_predict_unit #(
  parameter int unsigned IDX_BITS = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_f,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_br_valid,
  input  logic [31:0] i_br_pc,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_br_target,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_taken,
  output logic        o_mispredict,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  localparam int unsigned ENTRIES  = 2 ** IDX_BITS;
  localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } cnt_t;

  logic                tbl_valid  [ENTRIES];
  logic [TAG_BITS-1:0] tbl_tag    [ENTRIES];
  logic [31:0]         tbl_target [ENTRIES];
  cnt_t                tbl_cnt    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0] u_tag;
  logic                u_hit;
  logic                legal;
  logic                dec_taken;
  logic                upd;
  cnt_t                cnt_next;
  logic                unused_pc_lsbs;

  assign unused_pc_lsbs = ^{i_pc_f[1:0], i_br_pc[1:0]};

  // Fetch-side lookup reads the registered table only, so same-cycle updates are not bypassed.
  assign f_idx         = i_pc_f[IDX_BITS+1:2];
  assign f_tag         = i_pc_f[31:IDX_BITS+2];
  assign f_hit         = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
  assign o_pred_taken  = f_hit && tbl_cnt[f_idx][1];
  assign o_pred_target = f_hit ? tbl_target[f_idx] : '0;

  assign o_br_un = i_funct3[1];
  assign legal   = (i_funct3[2:1] != 2'b01);

  always_comb begin
    dec_taken = 1'b0;
    case (i_funct3)
      3'b000:         dec_taken = i_br_equal;
      3'b001:         dec_taken = !i_br_equal;
      3'b100, 3'b110: dec_taken = i_br_less;
      3'b101, 3'b111: dec_taken = !i_br_less;
      default:        dec_taken = 1'b0;
    endcase
  end

  assign upd          = i_br_valid && legal;
  assign o_br_taken   = upd && dec_taken;
  assign o_mispredict = upd && ((o_br_taken != i_pred_taken) ||
                                (o_br_taken && (i_pred_target != i_br_target)));

  assign u_idx = i_br_pc[IDX_BITS+1:2];
  assign u_tag = i_br_pc[31:IDX_BITS+2];
  assign u_hit = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);

  always_comb begin
    cnt_next = tbl_cnt[u_idx];
    if (!u_hit) begin
      cnt_next = o_br_taken ? WT : WN;
    end else if (o_br_taken) begin
      case (tbl_cnt[u_idx])
        SN:      cnt_next = WN;
        WN:      cnt_next = WT;
        default: cnt_next = ST;
      endcase
    end else begin
      case (tbl_cnt[u_idx])
        ST:      cnt_next = WT;
        WT:      cnt_next = WN;
        default: cnt_next = SN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_cnt[i]    <= WN;
      end
      o_br_count      <= '0;
      o_mispred_count <= '0;
    end else if (upd) begin
      tbl_valid[u_idx] <= 1'b1;
      tbl_tag[u_idx]   <= u_tag;
      // A not-taken hit keeps its old target; allocation always writes one.
      if (!u_hit || o_br_taken) begin
        tbl_target[u_idx] <= i_br_target;
      end
      tbl_cnt[u_idx] <= cnt_next;
      o_br_count     <= o_br_count + 32'd1;
      if (o_mispredict) begin
        o_mispred_count <= o_mispred_count + 32'd1;
      end
    end
  end

endmodule
